// File: rtl/program_memory_loader.sv
// ---------------------------------------------------------------------------
// program_memory_loader
//
// Instruction-side responder for an 8-bit single-cycle processor.
//
// A program image arrives over a byte-wide valid/ready stream. While that
// stream is active the processor is held. When loading finishes, the block
// sends a one-cycle restart pulse so that execution begins at PC 0. Fetches
// are answered combinationally from the stored image.
//
// Ports
//   clock          system clock (same clock as the processor PC)
//   clear          synchronous active-high reset
//   load_mode      level: 1 = load a program, 0 = run
//   load_valid     a byte is present on load_data
//   load_data      instruction byte to store
//   load_ready     a byte is accepted this cycle
//   read_address   fetch address from the processor PC
//   instruction    fetched instruction (FILL_INSTR outside the image)
//   cpu_hold       processor must not advance (any state but RUN)
//   cpu_clear      one-cycle restart pulse after a load completes
//   program_length number of bytes in the current image
//   overflow       sticky: a byte was offered while the memory was full
// ---------------------------------------------------------------------------
module program_memory_loader #(
    parameter int         DEPTH      = 256,
    parameter int         ADDR_W     = 8,
    parameter logic [7:0] FILL_INSTR = 8'h00
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load_mode,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] read_address,
    output logic [7:0]        instruction,
    output logic              cpu_hold,
    output logic              cpu_clear,
    output logic [ADDR_W:0]   program_length,
    output logic              overflow
);

    // Any address below DEPTH fits in IDX_W bits, so both the write pointer
    // and an in-image fetch address can be truncated to index the memory.
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t          state_reg, state_next;
    logic [ADDR_W:0] wptr_reg, wptr_next;
    logic [ADDR_W:0] length_reg, length_next;
    logic            overflow_reg, overflow_next;
    logic            cpu_clear_reg, cpu_clear_next;

    logic [7:0]      mem [DEPTH];

    logic            mem_full;
    logic            wr_en;
    logic            in_image;

    // ------------------------------------------------------------------
    // Next-state and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        wptr_next      = wptr_reg;
        length_next    = length_reg;
        overflow_next  = overflow_reg;
        cpu_clear_next = 1'b0;

        mem_full   = (wptr_reg >= DEPTH_W);
        // load_ready also needs load_mode. As a result, a byte offered on the
        // cycle in which load_mode falls is never accepted.
        load_ready = (state_reg == LOAD) && load_mode && !mem_full;
        wr_en      = load_valid && load_ready;

        case (state_reg)
            IDLE: begin
                if (load_mode) begin
                    state_next    = LOAD;
                    wptr_next     = '0;
                    length_next   = '0;
                    overflow_next = 1'b0;
                end else if (length_reg != '0) begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                if (!load_mode) begin
                    state_next     = RUN;
                    cpu_clear_next = 1'b1;
                end else if (wr_en) begin
                    wptr_next   = wptr_reg + ONE_W;
                    length_next = wptr_reg + ONE_W;
                end else if (load_valid && mem_full) begin
                    overflow_next = 1'b1;
                end
            end
            RUN: begin
                if (load_mode) begin
                    state_next    = LOAD;
                    wptr_next     = '0;
                    length_next   = '0;
                    overflow_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg     <= IDLE;
            wptr_reg      <= '0;
            length_reg    <= '0;
            overflow_reg  <= 1'b0;
            cpu_clear_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wptr_reg      <= wptr_next;
            length_reg    <= length_next;
            overflow_reg  <= overflow_next;
            cpu_clear_reg <= cpu_clear_next;
        end
    end

    // Program memory. It is never cleared: a zero program_length already
    // hides stale contents.
    always_ff @(posedge clock) begin
        if (wr_en && !clear) begin
            mem[wptr_reg[IDX_W-1:0]] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch path: zero latency, because the processor is single-cycle.
    // The bounds check also guarantees that the truncated index is in range.
    // ------------------------------------------------------------------
    always_comb begin
        in_image    = (state_reg == RUN) && ({1'b0, read_address} < length_reg);
        instruction = in_image ? mem[read_address[IDX_W-1:0]] : FILL_INSTR;
    end

    assign cpu_hold       = (state_reg != RUN);
    assign cpu_clear      = cpu_clear_reg;
    assign program_length = length_reg;
    assign overflow       = overflow_reg;

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Instruction-side responder for the 8-bit single-cycle microprocessor's fetch interface.
- Serves instruction[7:0] combinationally from the processor's read_address[7:0].
- Holds a RAM-backed program image loaded at run time through a byte-wide valid/ready stream, e.g. from switches or a UART byte receiver.
- Sequences the processor: keeps it held during a load, then issues a one-cycle restart pulse so execution begins at PC 0.

Parameters:
- DEPTH, 256: number of instruction bytes stored. Must be ≤ 2^ADDR_W.
- ADDR_W, 8: width of read_address and of the write pointer.
- FILL_INSTR, 8'h00: instruction returned for unloaded addresses and while loading.

Ports:
- clock  input  1  system clock; the same clock that drives the processor's PC.
- clear  input  1  reset; synchronous, active-high.
- load_mode  input  1  level. 1 requests program loading; 0 requests run.
- load_valid  input  1  load byte present on load_data.
- load_data  input  8  instruction byte to store.
- load_ready  output  1  block accepts a byte this cycle.
- read_address  input  ADDR_W  fetch address from the processor PC.
- instruction  output  8  fetched instruction.
- cpu_hold  output  1  high while the processor must not advance.
- cpu_clear  output  1  one-cycle restart pulse to the processor's clear.
- program_length  output  ADDR_W+1  number of bytes in the current image.
- overflow  output  1  sticky flag: a byte was offered while memory was full.

Behaviour:
- Reset (clear=1 at a clock edge):
  - state=IDLE, write pointer=0, program_length=0, overflow=0, cpu_clear=0.
  - Memory contents are not cleared; they are unreachable because program_length=0.
  - Reset overrides every other input in the same cycle, including mid-load. A partial image is discarded: length stays 0.
- States: IDLE, LOAD, RUN.
- Transitions:
  - IDLE→LOAD when load_mode=1.
  - RUN→LOAD when load_mode=1.
  - LOAD→RUN when load_mode=0.
  - IDLE→RUN when load_mode=0 and program_length>0. This cannot happen after reset, so IDLE holds until the first load.
- Entering LOAD (registered on the transition edge):
  - write pointer←0, program_length←0, overflow←0.
- Handshake:
  - load_ready = (state==LOAD) & load_mode & (wptr<DEPTH). Combinational from registered state.
  - A byte transfers on a clock edge where load_valid & load_ready. Then mem[wptr]←load_data, wptr←wptr+1, program_length←wptr+1.
  - load_valid is ignored when load_ready=0. No byte is lost silently except via overflow.
  - Back-to-back transfers are allowed: one byte per cycle.
- Full: when wptr==DEPTH, load_ready=0. load_valid=1 in LOAD then sets overflow=1, which stays set until the next LOAD entry or reset. Memory and length remain unchanged.
- Exiting LOAD:
  - On the LOAD→RUN edge, cpu_clear=1 for exactly the next cycle, then 0.
  - A byte offered in the same cycle load_mode falls is not accepted, because load_ready is already 0.
- cpu_hold = (state!=RUN). Combinational from state.
- Read path:
  - Combinational, zero latency.
  - instruction = mem[read_address] when state==RUN and read_address<program_length; otherwise FILL_INSTR.
  - Addresses beyond program_length, including PC wrap past 255 to 0 with a short image, return FILL_INSTR for high addresses. Wrap to 0 returns mem[0].
- Write/read collision: none architecturally, because reads return FILL_INSTR outside RUN and writes occur only in LOAD.
- Width rules:
  - program_length is ADDR_W+1 bits so that DEPTH=256 is representable (9'h100).
  - Comparisons are unsigned.

Test Plan:
- Reset then idle: clear=1 for 2 cycles, load_mode=0, read_address=8'h05 → instruction=8'h00, cpu_hold=1, program_length=0, load_ready=0, cpu_clear never pulses.
- Basic load and run:
  - Stimulus: load_mode=1, stream 8'h41, 8'h86, 8'hC3 with valid held 3 cycles, then load_mode=0.
  - Required: program_length=3, cpu_clear high exactly 1 cycle, cpu_hold=0 afterwards.
  - read_address 0/1/2/3 → 8'h41/8'h86/8'hC3/8'h00.
- Handshake gaps: valid toggles 1,0,1,0,1 with data 8'h11, 8'h22, 8'h33 on valid cycles → exactly 3 writes at addresses 0..2, program_length=3.
- Overflow with DEPTH=4:
  - Stimulus: stream 6 bytes 8'h01..8'h06.
  - Required: load_ready drops after the 4th byte, overflow=1, program_length=4, mem[3]=8'h04.
  - Re-entering LOAD clears overflow and program_length to 0.
- Reset mid-load: after 2 of 5 bytes, clear=1 for one cycle → state IDLE, program_length=0, any read returns 8'h00, no cpu_clear pulse.
- Reload from RUN:
  - Stimulus: run a 3-byte image, raise load_mode, load 8'hFF only, drop load_mode.
  - Required: cpu_hold=1 during load, read_address=8'h00 → 8'hFF, read_address=8'h01 → 8'h00 (stale data hidden), cpu_clear pulses once.
